// File: rtl/z2_bus_initiator.sv
// z2_bus_initiator: single-word 68000/Zorro II-style bus cycle initiator.
// Turns one request from an internal master into an AS_n/UDS_n/LDS_n/RW strobed cycle.
// The cycle ends on a synchronised DTACK_n, or is forced to finish by a timeout.
// All bus outputs come straight from flops, so input changes never reach the bus combinationally.

module z2_bus_initiator #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_be,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] rdata,
   output logic [22:0] ADDR,
   output logic        RW,
   output logic        AS_n,
   output logic        UDS_n,
   output logic        LDS_n,
   output logic [15:0] DOUT,
   output logic        DOE,
   input  logic [15:0] DIN,
   input  logic        DTACK_n
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ASSERT,
      S_WAIT,
      S_LATCH,
      S_END
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          dtack_m, dtack_s;
   logic          we_q;
   logic [1:0]    be_q;
   logic          accept;
   logic          timeout;
   logic          as_n_d, uds_n_d, lds_n_d;

   assign accept  = (state == S_IDLE) && req;
   assign timeout = (cnt == CNT_LAST);

   // Two-flop synchroniser bringing the asynchronous acknowledge into the CLK domain
   always_ff @(posedge CLK) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (RESET) begin
         dtack_m <= 1'b1;
         dtack_s <= 1'b1;
      end else begin
         dtack_m <= DTACK_n;
         dtack_s <= dtack_m;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode: DTACK is tested before the timeout so a simultaneous ack wins
   always_comb begin
      // NOTE: defaulting every comb output first keeps partial branches from inferring latches.
      next_state = state;
      case (state)
         S_IDLE:   if (req) next_state = S_ADDR;
         S_ADDR:   next_state = S_ASSERT;
         S_ASSERT: next_state = S_WAIT;
         S_WAIT: begin
            if (!dtack_s)     next_state = S_LATCH;
            else if (timeout) next_state = S_END;
         end
         S_LATCH:  next_state = S_END;
         S_END:    if (dtack_s || timeout) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Strobe decode for the state being entered; registered below so strobes are edge-aligned
   always_comb begin
      as_n_d  = 1'b1;
      uds_n_d = 1'b1;
      lds_n_d = 1'b1;
      case (next_state)
         S_ASSERT: begin
            as_n_d = 1'b0;
            // Writes hold data strobes off for one cycle of data setup
            if (!we_q) {uds_n_d, lds_n_d} = ~be_q;
         end
         S_WAIT, S_LATCH: begin
            as_n_d             = 1'b0;
            {uds_n_d, lds_n_d} = ~be_q;
         end
         default: ;
      endcase
   end

   // Timeout counter: cleared on every state change, saturating while a state persists
   always_ff @(posedge CLK) begin
      if (RESET)                    cnt <= '0;
      else if (next_state != state) cnt <= '0;
      else if (cnt != CNT_MAX)      cnt <= cnt + 1'b1;
   end

   // Request latch, bus output registers and master-side status
   always_ff @(posedge CLK) begin
      if (RESET) begin
         we_q  <= 1'b0;
         be_q  <= 2'b11;
         ADDR  <= '0;
         DOUT  <= '0;
         RW    <= 1'b1;
         DOE   <= 1'b0;
         AS_n  <= 1'b1;
         UDS_n <= 1'b1;
         LDS_n <= 1'b1;
         done  <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         AS_n  <= as_n_d;
         UDS_n <= uds_n_d;
         LDS_n <= lds_n_d;
         done  <= (state == S_END) && (next_state == S_IDLE);
         busy  <= (next_state != S_IDLE) || (state == S_END);
         if (accept) begin
            we_q <= req_we;
            be_q <= (req_be == 2'b00) ? 2'b11 : req_be;
            ADDR <= req_addr;
            DOUT <= req_wdata;
            RW   <= ~req_we;
            DOE  <= req_we;
            err  <= 1'b0;
         end
         if ((state == S_WAIT) && (next_state == S_END)) err <= 1'b1;
         if ((state == S_LATCH) && !we_q) rdata <= DIN;
         // RW and DOE are held through END for write hold time, released on return to IDLE
         if ((state == S_END) && (next_state == S_IDLE)) begin
            RW  <= 1'b1;
            DOE <= 1'b0;
         end
      end
   end

endmodule
